// File: rtl/dtw_pkg.sv
// dtw_pkg: shared definitions for the DTW reference-dump block.
//   - default widths for reference samples and reference memory addresses
//   - state encoding of the dump controller FSM
package dtw_pkg;

  localparam int DTW_DATA_WIDTH       = 16;
  localparam int DTW_REFMEM_PTR_WIDTH = 20;

  // Maximum number of words issued to the memory but not yet written out.
  localparam int DTW_MAX_INFLIGHT     = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } dtw_state_e;

endpackage : dtw_pkg

// File: rtl/dtw_ref_dump_skid.sv
// dtw_ref_dump_skid: 2-entry output buffer between the reference memory read
// port and the destination FIFO.
//   clk_in        : clock, rising edge
//   rst_n_in      : asynchronous active-low reset (already synchronised)
//   flush_in      : drop all buffered words (abort)
//   push_in       : read data for an issued address is on push_data_in now
//   push_data_in  : reference memory read data
//   full_in       : destination FIFO full
//   wren_out      : destination FIFO write enable (head valid and not full)
//   data_out      : destination FIFO write data (head entry)
//
// Handshake: the head entry is offered whenever the buffer is non-empty; it is
// consumed exactly in a cycle where wren_out=1, i.e. valid and not full. While
// full is high the head register is untouched, so data_out holds steady.
// The caller guarantees no push into a full (2-entry) buffer without a pop.
module dtw_ref_dump_skid #(
  parameter int DATA_WIDTH = dtw_pkg::DTW_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  flush_in,
  input  logic                  push_in,
  input  logic [DATA_WIDTH-1:0] push_data_in,
  input  logic                  full_in,
  output logic                  wren_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [1:0]            count_q, count_d;
  logic                  pop;

  // Registered valid, combinational on full.
  assign pop      = (count_q != 2'd0) && !full_in;
  assign wren_out = pop;
  assign data_out = head_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_in) begin
      count_d = 2'd0;
    end else begin
      case ({push_in, pop})
        2'b10: begin
          if (count_q == 2'd0) head_d = push_data_in;
          else                 tail_d = push_data_in;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the new word lands behind whatever remains.
          if (count_q == 2'd1) begin
            head_d = push_data_in;
          end else begin
            head_d = tail_q;
            tail_d = push_data_in;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule : dtw_ref_dump_skid

// File: rtl/dtw_ref_dump.sv
// dtw_ref_dump: streams words 0..len-1 of the reference memory into a
// destination FIFO.
//   clk_in / rst_n_in          : clock (rising edge), async active-low reset
//   start_in, ref_len_in       : dump request and length (latched on accept)
//   abort_in                   : cancel an active dump (STREAM/DRAIN)
//   busy_out, done_out         : activity flag, one-cycle completion pulse
//   ref_addr_out, ref_data_in  : memory read port, one cycle read latency
//   dst_fifo_wren_out/_full_in/_data_out : destination FIFO write port
//   words_sent_out             : words written in the current or last dump
//   checksum_out               : only with DTW_REF_DUMP_CHKSUM_EN defined; sum
//                                mod 2^DATA_WIDTH of the words written
//   state_dbg_out              : current FSM state
//
// Flow: an address is issued when fewer than two words are in flight or a
// write retires one in the same cycle. Read data is pushed into the skid
// buffer one cycle after issue, so a full FIFO can never cause loss.
module dtw_ref_dump #(
  parameter int DATA_WIDTH       = dtw_pkg::DTW_DATA_WIDTH,
  parameter int REFMEM_PTR_WIDTH = dtw_pkg::DTW_REFMEM_PTR_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        start_in,
  input  logic                        abort_in,
  input  logic [REFMEM_PTR_WIDTH-1:0] ref_len_in,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [REFMEM_PTR_WIDTH-1:0] ref_addr_out,
  input  logic [DATA_WIDTH-1:0]       ref_data_in,
  output logic                        dst_fifo_wren_out,
  input  logic                        dst_fifo_full_in,
  output logic [DATA_WIDTH-1:0]       dst_fifo_data_out,
`ifdef DTW_REF_DUMP_CHKSUM_EN
  output logic [DATA_WIDTH-1:0]       checksum_out,
`endif
  output logic [REFMEM_PTR_WIDTH-1:0] words_sent_out,
  output logic [1:0]                  state_dbg_out
);
  import dtw_pkg::*;

  localparam logic [REFMEM_PTR_WIDTH-1:0] PTR_ONE = REFMEM_PTR_WIDTH'(1);
  localparam logic [1:0] MAX_INFLIGHT = 2'(DTW_MAX_INFLIGHT);

  dtw_state_e                  state_q, state_d;
  logic [REFMEM_PTR_WIDTH-1:0] len_q, len_d;
  logic [REFMEM_PTR_WIDTH-1:0] addr_q, addr_d;
  logic [REFMEM_PTR_WIDTH-1:0] words_q, words_d;
  logic [1:0]                  inflight_q, inflight_d;
  logic                        rd_pend_q, rd_pend_d;
  logic                        rst_sync_q, rst_sync_d;
  logic                        rst_n;

  logic start_accept, abort_hit, issue, last_issue, wren;
  logic [DATA_WIDTH-1:0] wr_data;

  // Reset asserts asynchronously but releases on a clock edge, so the first
  // edge after deassertion still sees reset and the second one is live.
  assign rst_sync_d = 1'b1;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync_q <= 1'b0;
    else           rst_sync_q <= rst_sync_d;
  end
  assign rst_n = rst_sync_q;

  assign start_accept = (state_q == ST_IDLE) && start_in;
  assign abort_hit    = abort_in && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
  assign issue        = (state_q == ST_STREAM) && !abort_in &&
                        ((inflight_q < MAX_INFLIGHT) || wren);
  assign last_issue   = issue && (addr_q == (len_q - PTR_ONE));

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_in) state_d = (ref_len_in == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (abort_in)        state_d = ST_IDLE;
        else if (last_issue) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (abort_in)                state_d = ST_IDLE;
        else if (inflight_d == 2'd0) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_out      = (state_q != ST_IDLE);
    done_out      = (state_q == ST_DONE);
    state_dbg_out = state_q;
  end

  // Counters and read tracking
  always_comb begin
    len_d      = len_q;
    addr_d     = addr_q;
    inflight_d = inflight_q;
    rd_pend_d  = 1'b0;
    words_d    = words_q + REFMEM_PTR_WIDTH'(wren);
    if (start_accept) begin
      len_d      = ref_len_in;
      addr_d     = '0;
      inflight_d = 2'd0;
      words_d    = '0;
    end else if (abort_hit) begin
      inflight_d = 2'd0;
    end else begin
      addr_d     = addr_q + REFMEM_PTR_WIDTH'(issue);
      inflight_d = inflight_q + {1'b0, issue} - {1'b0, wren};
      rd_pend_d  = issue;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      addr_q     <= '0;
      inflight_q <= 2'd0;
      rd_pend_q  <= 1'b0;
      words_q    <= '0;
    end else begin
      len_q      <= len_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      rd_pend_q  <= rd_pend_d;
      words_q    <= words_d;
    end
  end

  dtw_ref_dump_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n),
    .flush_in     (abort_hit),
    .push_in      (rd_pend_q),
    .push_data_in (ref_data_in),
    .full_in      (dst_fifo_full_in),
    .wren_out     (wren),
    .data_out     (wr_data)
  );

  assign ref_addr_out      = addr_q;
  assign dst_fifo_wren_out = wren;
  assign dst_fifo_data_out = wr_data;
  assign words_sent_out    = words_q;

`ifdef DTW_REF_DUMP_CHKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (start_accept) chk_d = '0;
    else if (wren)    chk_d = chk_q + wr_data;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end

  assign checksum_out = chk_q;
`endif

endmodule : dtw_ref_dump

// File: tb/tb_dtw_ref_dump.sv
// tb_dtw_ref_dump: self-checking bench for dtw_ref_dump.
// Define DTW_REF_DUMP_CHKSUM_EN to also exercise the checksum output.
module tb_dtw_ref_dump;

  localparam int DW      = 16;
  localparam int PW      = 20;
  localparam int MAX_CYC = 400;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_in, abort_in, full;
  logic [PW-1:0] ref_len_in;
  logic          busy, done, wren;
  logic [PW-1:0] ref_addr, words_sent;
  logic [DW-1:0] ref_data, data;
  logic [1:0]    state_dbg;
`ifdef DTW_REF_DUMP_CHKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  dtw_ref_dump #(.DATA_WIDTH(DW), .REFMEM_PTR_WIDTH(PW)) dut (
    .clk_in            (clk),
    .rst_n_in          (rst_n),
    .start_in          (start_in),
    .abort_in          (abort_in),
    .ref_len_in        (ref_len_in),
    .busy_out          (busy),
    .done_out          (done),
    .ref_addr_out      (ref_addr),
    .ref_data_in       (ref_data),
    .dst_fifo_wren_out (wren),
    .dst_fifo_full_in  (full),
    .dst_fifo_data_out (data),
`ifdef DTW_REF_DUMP_CHKSUM_EN
    .checksum_out      (checksum),
`endif
    .words_sent_out    (words_sent),
    .state_dbg_out     (state_dbg)
  );

  // Reference memory: one-cycle read latency.
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) ref_data <= mem[ref_addr[5:0]];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] chk_model;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Cycle 0 holds start high; the following edge is the start sampling edge
  // and cycle n is the n-th cycle after it. Inputs are driven on the falling
  // edge and outputs sampled 1 time unit later.
  task automatic run_dump(input int len, input bit rand_mode, input int full_s,
                          input int full_n, input int abort_after,
                          output int n_wr, output int first_wr, output int last_wr,
                          output int done_cyc, output int n_done, output int end_cyc);
    bit abort_pend, aborted, prev_busy, prev_done, finished;
    logic [DW-1:0] exp_w;
    n_wr = 0; first_wr = 0; last_wr = 0; done_cyc = 0; n_done = 0; end_cyc = 0;
    abort_pend = 0; aborted = 0; finished = 0;
    exp_q.delete();
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    chk_model = '0;
    @(negedge clk);
    start_in = 1'b1; ref_len_in = PW'(len); abort_in = 1'b0; full = 1'b0;
    #1;
    prev_busy = busy; prev_done = done;
    for (int cyc = 1; cyc <= MAX_CYC && !finished; cyc++) begin
      @(negedge clk);
      // Stray starts while active must be ignored; never drive one into IDLE.
      start_in   = (rand_mode && prev_busy && !prev_done) ? ($urandom_range(0, 7) == 0) : 1'b0;
      ref_len_in = PW'($urandom);
      if (rand_mode) full = ($urandom_range(0, 2) == 0);
      else           full = (cyc >= full_s) && (cyc < full_s + full_n);
      abort_in = 1'b0;
      if (abort_pend) begin
        abort_in = 1'b1; full = 1'b1; abort_pend = 0; aborted = 1;
      end
      #1;
      if (wren) begin
        n_wr++;
        if (first_wr == 0) first_wr = cyc;
        last_wr = cyc;
        check("no_wren_while_full", {31'd0, full}, 32'd0);
        if (exp_q.size() == 0) check("extra_write", n_wr, len);
        else begin
          exp_w = exp_q.pop_front();
          check("write_data", {16'd0, data}, {16'd0, exp_w});
        end
        chk_model = chk_model + data;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (!aborted && !abort_pend && abort_after > 0 && n_wr == abort_after) abort_pend = 1;
      if (!busy) begin finished = 1; end_cyc = cyc; end
      prev_busy = busy; prev_done = done;
    end
    check("dump_finished", {31'd0, finished}, 32'd1);
    start_in = 1'b0; abort_in = 1'b0;
    if (aborted) exp_q.delete();
    else check("all_words_written", exp_q.size(), 0);
`ifdef DTW_REF_DUMP_CHKSUM_EN
    check("checksum_model", {16'd0, checksum}, {16'd0, chk_model});
`endif
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int len; int full_s; int full_n; int abort_after;
    int exp_words; int exp_nwr; int exp_first; int exp_done_cyc; int exp_ndone; int exp_end;
  } vec_t;
  vec_t vecs[7];

  initial begin
    int n_wr, first_wr, last_wr, done_cyc, n_done, end_cyc, len, wait_cyc;
    rst_n = 1'b0; start_in = 1'b0; abort_in = 1'b0; full = 1'b0; ref_len_in = '0;
    for (int i = 0; i < 64; i++) mem[i] = DW'(16'h0100 + i);

    //            len fs fn ab  words nwr first done ndone end
    vecs[0] = '{  8, 0, 0, 0,  8,    8,  3,    11,  1,    12};
    vecs[1] = '{  8, 4, 5, 0,  8,    8,  3,    16,  1,    17};
    vecs[2] = '{  0, 0, 0, 0,  0,    0,  0,    1,   1,    2};
    vecs[3] = '{ 16, 0, 0, 5,  5,    5,  3,    0,   0,    9};
    vecs[4] = '{  8, 0, 0, 0,  8,    8,  3,    11,  1,    12};
    vecs[5] = '{  1, 0, 0, 0,  1,    1,  3,    4,   1,    5};
    vecs[6] = '{  2, 0, 0, 0,  2,    2,  3,    5,   1,    6};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_wren", {31'd0, wren}, 0);
    check("rst_addr", ref_addr, 0);
    check("rst_data", {16'd0, data}, 0);
    check("rst_words", words_sent, 0);
`ifdef DTW_REF_DUMP_CHKSUM_EN
    check("rst_checksum", {16'd0, checksum}, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table
    foreach (vecs[v]) begin
      run_dump(vecs[v].len, 1'b0, vecs[v].full_s, vecs[v].full_n, vecs[v].abort_after,
               n_wr, first_wr, last_wr, done_cyc, n_done, end_cyc);
      check($sformatf("v%0d_words_sent", v), words_sent, vecs[v].exp_words);
      check($sformatf("v%0d_n_writes", v), n_wr, vecs[v].exp_nwr);
      check($sformatf("v%0d_first_wren_cyc", v), first_wr, vecs[v].exp_first);
      check($sformatf("v%0d_done_cyc", v), done_cyc, vecs[v].exp_done_cyc);
      check($sformatf("v%0d_done_pulses", v), n_done, vecs[v].exp_ndone);
      check($sformatf("v%0d_idle_cyc", v), end_cyc, vecs[v].exp_end);
    end

    // Randomized dumps with random backpressure and memory contents
    for (int r = 0; r < 20; r++) begin
      len = $urandom_range(0, 32);
      for (int i = 0; i < 64; i++) mem[i] = DW'($urandom);
      run_dump(len, 1'b1, 0, 0, 0, n_wr, first_wr, last_wr, done_cyc, n_done, end_cyc);
      check("rnd_n_writes", n_wr, len);
      check("rnd_words_sent", words_sent, len);
      check("rnd_done_pulses", n_done, 1);
      check("rnd_done_after_last", done_cyc, (len == 0) ? 1 : last_wr + 1);
    end

`ifdef DTW_REF_DUMP_CHKSUM_EN
    // Checksum wraps modulo 2^16
    mem[0] = 16'hFFFF; mem[1] = 16'h0001; mem[2] = 16'h0002; mem[3] = 16'h0003;
    run_dump(4, 1'b0, 0, 0, 0, n_wr, first_wr, last_wr, done_cyc, n_done, end_cyc);
    check("checksum_wrap", {16'd0, checksum}, 32'h0005);
`endif

    // Asynchronous reset mid-dump, then reset release timing
    for (int i = 0; i < 64; i++) mem[i] = DW'(16'h0100 + i);
    @(negedge clk);
    start_in = 1'b1; ref_len_in = PW'(16);
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    check("arst_wren", {31'd0, wren}, 0);
    check("arst_addr", ref_addr, 0);
    check("arst_data", {16'd0, data}, 0);
    check("arst_words", words_sent, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; start_in = 1'b1; ref_len_in = PW'(3);
    @(negedge clk); #1;
    check("start_ignored_1st_edge", {31'd0, busy}, 0);
    @(negedge clk); #1;
    check("start_taken_2nd_edge", {31'd0, busy}, 1);
    start_in = 1'b0;
    wait_cyc = 0;
    while (busy && wait_cyc < 50) begin
      @(negedge clk); #1;
      wait_cyc++;
    end
    check("post_reset_dump_idle", {31'd0, busy}, 0);
    check("post_reset_words", words_sent, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_dtw_ref_dump
